// File: rtl/koniec_pkg.sv
// rtl/koniec_pkg.sv - shared types and constants for the end-of-game text controller
package koniec_pkg;

  typedef enum logic [2:0] {CLEAR, IDLE, WAIT, WRITE, DONE} state_t;

  localparam int MSG_LEN_DEF   = 32;
  localparam int FRAME_DIV_DEF = 4;
  localparam logic [6:0] BLANK_CODE = 7'h20;

  // "GAME OVER - KONIEC GRY - BYE :)!" as 7-bit ASCII, repeated for longer messages
  localparam logic [6:0] MSG_TEXT [32] = '{
    7'h47, 7'h41, 7'h4D, 7'h45, 7'h20, 7'h4F, 7'h56, 7'h45,
    7'h52, 7'h20, 7'h2D, 7'h20, 7'h4B, 7'h4F, 7'h4E, 7'h49,
    7'h45, 7'h43, 7'h20, 7'h47, 7'h52, 7'h59, 7'h20, 7'h2D,
    7'h20, 7'h42, 7'h59, 7'h45, 7'h20, 7'h3A, 7'h29, 7'h21
  };

endpackage

// File: rtl/koniec_msg_rom.sv
// rtl/koniec_msg_rom.sv - combinational message text lookup, blank beyond the message length
module koniec_msg_rom
  import koniec_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF
) (
  input  logic [7:0] addr,
  output logic [6:0] code
);

  always_comb begin
    code = BLANK_CODE;
    if ({1'b0, addr} < 9'(MSG_LEN)) code = MSG_TEXT[addr[4:0]];
  end

endmodule

// File: rtl/koniec_text_ctrl.sv
// rtl/koniec_text_ctrl.sv - frame-paced message writer into a 256-cell character buffer
module koniec_text_ctrl
  import koniec_pkg::*;
#(
  parameter int MSG_LEN   = MSG_LEN_DEF,
  parameter int FRAME_DIV = FRAME_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       vblnk,
  input  logic [7:0] rd_addr,
  output logic [6:0] rd_code,
  output logic       busy,
  output logic       done
);

  state_t     state;
  logic [7:0] clr_ptr;
  logic [8:0] idx;
  logic [7:0] fcnt;
  logic       vblnk_d;
  logic       clr_to_wait;
  logic       tick;
  logic       we;
  logic [7:0] wr_addr;
  logic [6:0] wr_data;
  logic [6:0] msg_code;
  logic [6:0] mem [256];

  assign tick = vblnk & ~vblnk_d;

  koniec_msg_rom #(.MSG_LEN(MSG_LEN)) u_msg_rom (
    .addr (idx[7:0]),
    .code (msg_code)
  );

  // Abort and reset suppress the pending write so nothing lands after the stop.
  always_comb begin
    we      = 1'b0;
    wr_addr = clr_ptr;
    wr_data = BLANK_CODE;
    if (!rst && !abort) begin
      if (state == CLEAR) begin
        we = 1'b1;
      end else if (state == WRITE) begin
        we      = 1'b1;
        wr_addr = idx[7:0];
        wr_data = msg_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_code <= '0;
    else     rd_code <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      idx         <= '0;
      fcnt        <= '0;
      vblnk_d     <= 1'b0;
      clr_to_wait <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
      case (state)
        CLEAR: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 8'd1;
            if (clr_ptr == 8'hFF) begin
              state <= clr_to_wait ? WAIT : IDLE;
              busy  <= clr_to_wait;
            end
          end
        end
        IDLE: begin
          if (start && !abort) begin
            state       <= CLEAR;
            clr_ptr     <= '0;
            idx         <= '0;
            fcnt        <= '0;
            clr_to_wait <= 1'b1;
            busy        <= 1'b1;
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            if (fcnt == 8'(FRAME_DIV - 1)) begin
              fcnt  <= '0;
              state <= WRITE;
            end else begin
              fcnt <= fcnt + 8'd1;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 9'd1;
            if (idx == 9'(MSG_LEN - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        DONE: begin
          if (start) begin
            state       <= CLEAR;
            clr_ptr     <= '0;
            idx         <= '0;
            fcnt        <= '0;
            clr_to_wait <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/koniec_text_ctrl.md
KONIEC_TEXT_CTRL -- requirements
Module: koniec_text_ctrl

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32, number of message characters written (1..256).
REQ-002 SHALL have parameter FRAME_DIV, default 4, frames between consecutive character writes (1..255).
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse; begins a message sequence.
REQ-006 SHALL have port abort  input  1  single-cycle pulse; stops the sequence and keeps buffer contents.
REQ-007 SHALL have port vblnk  input  1  vertical blank from the VGA timing chain; its rising edge is the frame tick.
REQ-008 SHALL have port rd_addr  input  8  character cell address {row[3:0], col[3:0]} from the char-rect draw stage.
REQ-009 SHALL have port rd_code  output  7  character code at rd_addr, for font ROM lookup.
REQ-010 SHALL have port busy  output  1  high in CLEAR, WAIT and WRITE.
REQ-011 SHALL have port done  output  1  high in DONE.

Function
REQ-012 SHALL hold a 256x7 character buffer with one write port (internal) and one read port (rd_addr).
REQ-013 SHALL register rd_code: data for rd_addr sampled at edge N appears after edge N+1 (1-cycle latency).
REQ-014 SHALL return the old contents when the read and write addresses are equal in the same cycle (read-before-write).
REQ-015 SHALL implement FSM states CLEAR, IDLE, WAIT, WRITE, DONE.
REQ-016 CLEAR: write 0x20 to address clr_ptr, clr_ptr 0..255, one per cycle; after address 255 -> WAIT if entered from start, else -> IDLE.
REQ-017 IDLE: start -> CLEAR with clr_ptr=0, char index idx=0, frame counter fcnt=0.
REQ-018 WAIT: on each frame tick fcnt increments; when fcnt reaches FRAME_DIV-1 on a tick, fcnt<=0 and -> WRITE.
REQ-019 WRITE: write msg_rom[idx] to buffer address idx in one cycle; idx increments; if idx was MSG_LEN-1 -> DONE, else -> WAIT.
REQ-020 DONE: hold done=1 and buffer contents; start -> CLEAR (restart); abort has no effect.
REQ-021 SHALL generate the frame tick as vblnk & ~vblnk_d, with vblnk_d a one-cycle registered copy.
REQ-022 SHALL ignore frame ticks outside WAIT; ticks are not queued.
REQ-023 SHALL ignore start in CLEAR, WAIT and WRITE.
REQ-024 abort in CLEAR, WAIT or WRITE -> IDLE next cycle; clear already performed stays; characters already written stay; if start and abort coincide, abort wins.
REQ-025 SHALL size idx 9 bits and fcnt 8 bits; no wrap-around, since transitions occur at MSG_LEN-1 and FRAME_DIV-1.
REQ-026 SHALL write exactly one buffer entry per cycle at most.

Reset
REQ-027 rst SHALL force CLEAR with clr_ptr=0, idx=0, fcnt=0, vblnk_d=0, rd_code=0, done=0, busy=1; after clear completes -> IDLE.
REQ-028 rst asserted mid-sequence SHALL abandon it; the buffer becomes all 0x20 again via CLEAR.
REQ-029 Buffer contents SHALL NOT be reset directly; only the CLEAR sweep initialises them.

Structure
REQ-030 SHALL place the FSM state typedef, MSG_LEN default, FRAME_DIV default and the blank code 0x20 in a shared package koniec_pkg.
REQ-031 SHALL put the message text in sub-module koniec_msg_rom (combinational, 8-bit address -> 7-bit code; 0x20 beyond MSG_LEN).
REQ-032 SHALL infer the buffer as block/distributed RAM: no reset on the array, registered read.

Verification
REQ-033 After rst release: busy=1 for 256 cycles, then IDLE; reading addresses 0, 128 and 255 gives rd_code=0x20.
REQ-034 FRAME_DIV=2, MSG_LEN=4, start then 8 vblnk rising edges: chars 0..3 written after ticks 2, 4, 6, 8; done=1 after the 8th tick; addr 4 stays 0x20.
REQ-035 rd_addr=3 held while WRITE writes addr 3: rd_code is old 0x20 the next cycle and the new code one cycle later.
REQ-036 abort after 2 of 4 chars: IDLE next cycle, busy=0, done=0; addrs 0-1 hold the message, addrs 2-3 hold 0x20; further ticks cause no writes.
REQ-037 start pulsed in WAIT: no effect; start in DONE: 256-cycle clear, then the sequence repeats identically.
REQ-038 rst asserted in WRITE: next cycle busy=1, done=0, rd_code=0; after 256 cycles all addrs read 0x20.
